// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of the two master ports and the memory port of mem_arbiter.
//
// Signals (directions seen from the arbiter, i.e. the slave modport):
//   m0_req/m0_we/m0_adr/m0_wd  in   CPU port request, write enable, address, write data
//   m0_rd/m0_ack               out  CPU port read data and completion pulse
//   m1_*                       same set for the debug/DMA port
//   m0_lock                    in   CPU lock request (only when MEM_ARB_LOCK_EN is defined)
//   mem_en/mem_we/mem_adr/mem_wd out memory strobe, write strobe, address, write data
//   mem_rd                     in   memory read data
//   busy                       out  arbiter not idle
// Optional feature macro: MEM_ARB_LOCK_EN.

interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_wd;
    logic [DW-1:0] m0_rd;
    logic          m0_ack;
`ifdef MEM_ARB_LOCK_EN
    logic          m0_lock;
`endif
    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_wd;
    logic [DW-1:0] m1_rd;
    logic          m1_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          busy;

    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  m0_lock,
`endif
        input  m0_req, m0_we, m0_adr, m0_wd,
        output m0_rd, m0_ack,
        input  m1_req, m1_we, m1_adr, m1_wd,
        output m1_rd, m1_ack,
        output mem_en, mem_we, mem_adr, mem_wd,
        input  mem_rd,
        output busy
    );

    modport master (
`ifdef MEM_ARB_LOCK_EN
        output m0_lock,
`endif
        output m0_req, m0_we, m0_adr, m0_wd,
        input  m0_rd, m0_ack,
        output m1_req, m1_we, m1_adr, m1_wd,
        input  m1_rd, m1_ack,
        input  mem_en, mem_we, mem_adr, mem_wd,
        output mem_rd,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-ported memory between the multicycle CPU (m0) and a
// debug/DMA master (m1). Round-robin between the ports, one access at a time:
// IDLE (grant) -> ACCESS (WAIT cycles of mem_en) -> DONE (one-cycle ack) -> IDLE.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous, active-low reset
//   bus    mem_arbiter_if.slave: m0_*/m1_* master ports, mem_* memory port, busy
// Parameters: AW address width, DW data width, WAIT memory access cycles (1..15).
// Optional feature macro: MEM_ARB_LOCK_EN adds m0_lock; a lock seen in the DONE cycle of
// an m0 access lets a following m0 request win regardless of round-robin.

module mem_arbiter #(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned WAIT = 2
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam logic [3:0] WaitLoad = 4'(WAIT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          grant_q;   // 0: m0, 1: m1
    logic          last_q;    // most recent grantee
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_adr_q;
    logic [DW-1:0] mem_wd_q;
    logic [DW-1:0] m0_rd_q;
    logic [DW-1:0] m1_rd_q;
    logic          m0_ack_q;
    logic          m1_ack_q;
    logic          busy_q;
`ifdef MEM_ARB_LOCK_EN
    logic          lock_q;
`endif

    logic any_req;
    logic pick;

    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            pick = ~last_q;
        end else begin
            pick = bus.m1_req;
        end
`ifdef MEM_ARB_LOCK_EN
        if (lock_q && bus.m0_req) begin
            pick = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;   // so m0 wins the first contested grant
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_wd_q  <= '0;
            m0_rd_q   <= '0;
            m1_rd_q   <= '0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_q   <= pick;
                        last_q    <= pick;
                        cnt_q     <= WaitLoad;
                        mem_en_q  <= 1'b1;
                        mem_we_q  <= pick ? bus.m1_we  : bus.m0_we;
                        mem_adr_q <= pick ? bus.m1_adr : bus.m0_adr;
                        mem_wd_q  <= pick ? bus.m1_wd  : bus.m0_wd;
                        busy_q    <= 1'b1;
                        state_q   <= StAccess;
`ifdef MEM_ARB_LOCK_EN
                        lock_q    <= 1'b0;
`endif
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        // Last access cycle: read data is valid now.
                        if (!mem_we_q) begin
                            if (grant_q) begin
                                m1_rd_q <= bus.mem_rd;
                            end else begin
                                m0_rd_q <= bus.mem_rd;
                            end
                        end
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        m0_ack_q <= ~grant_q;
                        m1_ack_q <= grant_q;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
`ifdef MEM_ARB_LOCK_EN
                    lock_q   <= ~grant_q & bus.m0_lock;
`endif
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.mem_en  = mem_en_q;
    assign bus.mem_we  = mem_we_q;
    assign bus.mem_adr = mem_adr_q;
    assign bus.mem_wd  = mem_wd_q;
    assign bus.m0_rd   = m0_rd_q;
    assign bus.m1_rd   = m1_rd_q;
    assign bus.m0_ack  = m0_ack_q;
    assign bus.m1_ack  = m1_ack_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter (WAIT=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_mem_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .WAIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        int we_cnt;
        int a0_cnt;
        int a1_cnt;
        int n_ack;
        int k;
        logic [31:0] exp_adr;

        bus.m0_req = 0; bus.m0_we = 0; bus.m0_adr = 0; bus.m0_wd = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_adr = 0; bus.m1_wd = 0;
        bus.mem_rd = 0;
`ifdef MEM_ARB_LOCK_EN
        bus.m0_lock = 0;
`endif
        // Reset values
        reset = 0;
        tick();
        tick();
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_m0_ack", 32'(bus.m0_ack), 32'd0);
        check("rst_m1_ack", 32'(bus.m1_ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_m0_rd", bus.m0_rd, 32'd0);
        check("rst_m1_rd", bus.m1_rd, 32'd0);
        check("rst_mem_adr", bus.mem_adr, 32'd0);
        check("rst_mem_wd", bus.mem_wd, 32'd0);
        reset = 1;
        tick();
        check("idle_mem_en", 32'(bus.mem_en), 32'd0);

        // m0 read of 0x40; req dropped right after the grant
        bus.m0_adr = 32'h40; bus.m0_we = 0; bus.mem_rd = 32'hDEADBEEF; bus.m0_req = 1;
        tick();
        check("rd_c1_en", 32'(bus.mem_en), 32'd1);
        check("rd_c1_we", 32'(bus.mem_we), 32'd0);
        check("rd_c1_adr", bus.mem_adr, 32'h40);
        check("rd_c1_busy", 32'(bus.busy), 32'd1);
        bus.m0_req = 0;
        tick();
        check("rd_c2_en", 32'(bus.mem_en), 32'd1);
        check("rd_c2_ack", 32'(bus.m0_ack), 32'd0);
        tick();
        check("rd_c3_en", 32'(bus.mem_en), 32'd0);
        check("rd_c3_ack0", 32'(bus.m0_ack), 32'd1);
        check("rd_c3_ack1", 32'(bus.m1_ack), 32'd0);
        check("rd_c3_rd", bus.m0_rd, 32'hDEADBEEF);
        tick();
        check("rd_c4_ack0", 32'(bus.m0_ack), 32'd0);
        check("rd_c4_busy", 32'(bus.busy), 32'd0);

        // m1 write; an m0 pulse during the access is dropped before any grant
        bus.m1_adr = 32'h100; bus.m1_wd = 32'h12345678; bus.m1_we = 1; bus.m1_req = 1;
        bus.mem_rd = 32'h55555555;
        en_cnt = 0; we_cnt = 0; a0_cnt = 0; a1_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.mem_en) en_cnt++;
            if (bus.mem_we && bus.mem_adr == 32'h100 && bus.mem_wd == 32'h12345678) we_cnt++;
            if (bus.m0_ack) a0_cnt++;
            if (bus.m1_ack) a1_cnt++;
            if (c == 1) bus.m1_req = 0;
            if (c == 2) bus.m0_req = 1;
            if (c == 3) bus.m0_req = 0;
        end
        check("wr_en_cycles", 32'(en_cnt), 32'd2);
        check("wr_we_cycles", 32'(we_cnt), 32'd2);
        check("wr_m1_acks", 32'(a1_cnt), 32'd1);
        check("wr_m0_acks", 32'(a0_cnt), 32'd0);
        check("wr_m1_rd", bus.m1_rd, 32'd0);
        check("wr_m0_rd_hold", bus.m0_rd, 32'hDEADBEEF);
        bus.m1_we = 0;

        // m0 read of 0x40; address/we/wd change after the grant are ignored
        bus.m0_adr = 32'h40; bus.m0_we = 0; bus.mem_rd = 32'hCAFEF00D; bus.m0_req = 1;
        tick();
        check("lat_c1_adr", bus.mem_adr, 32'h40);
        bus.m0_adr = 32'h80; bus.m0_we = 1; bus.m0_wd = 32'hFFFF0000; bus.m0_req = 0;
        tick();
        check("lat_c2_en", 32'(bus.mem_en), 32'd1);
        check("lat_c2_adr", bus.mem_adr, 32'h40);
        check("lat_c2_we", 32'(bus.mem_we), 32'd0);
        tick();
        check("lat_c3_ack", 32'(bus.m0_ack), 32'd1);
        check("lat_c3_rd", bus.m0_rd, 32'hCAFEF00D);
        tick();
        bus.m0_we = 0;

        // Reset in the second ACCESS cycle of an m1 read aborts it
        bus.m1_adr = 32'h300; bus.m1_we = 0; bus.mem_rd = 32'h0BADF00D; bus.m1_req = 1;
        tick();
        bus.m1_req = 0;
        tick();
        check("abt_c2_en", 32'(bus.mem_en), 32'd1);
        reset = 0;
        tick();
        check("abt_en", 32'(bus.mem_en), 32'd0);
        check("abt_busy", 32'(bus.busy), 32'd0);
        check("abt_ack1", 32'(bus.m1_ack), 32'd0);
        check("abt_m1_rd", bus.m1_rd, 32'd0);
        check("abt_m0_rd", bus.m0_rd, 32'd0);
        reset = 1;
        tick();
        check("abt_late_ack1", 32'(bus.m1_ack), 32'd0);

        // Both ports held: m0, m1, m0, m1 with acks 4 cycles apart
        bus.m0_adr = 32'h40; bus.m0_we = 0; bus.m1_adr = 32'h200; bus.m1_we = 0;
        bus.mem_rd = 32'h11111111; bus.m0_req = 1; bus.m1_req = 1;
        n_ack = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("rr_both_acks", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
            if (c % 4 == 1) begin
                k = (c - 1) / 4;
                exp_adr = (k % 2 == 0) ? 32'h40 : 32'h200;
                check("rr_grant_adr", bus.mem_adr, exp_adr);
            end
            if (bus.m0_ack || bus.m1_ack) begin
                check("rr_ack_port", 32'(bus.m1_ack), 32'(n_ack % 2));
                check("rr_ack_cycle", 32'(c), 32'(3 + 4 * n_ack));
                n_ack++;
            end
        end
        check("rr_ack_count", 32'(n_ack), 32'd4);
        bus.m0_req = 0; bus.m1_req = 0;
        for (int c = 0; c < 10 && bus.busy; c++) tick();
        check("rr_idle", 32'(bus.busy), 32'd0);

`ifdef MEM_ARB_LOCK_EN
        // Lock held through the first m0 DONE: m0, m0, then m1
        reset = 0;
        tick();
        reset = 1;
        bus.m0_lock = 1; bus.m0_req = 1; bus.m1_req = 1;
        n_ack = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 4) bus.m0_lock = 0;
            if (bus.m0_ack || bus.m1_ack) begin
                if (n_ack < 3) begin
                    check("lock_ack_port", 32'(bus.m1_ack), (n_ack == 2) ? 32'd1 : 32'd0);
                end
                n_ack++;
            end
        end
        check("lock_ack_count", 32'(n_ack), 32'd4);
        bus.m0_req = 0; bus.m1_req = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- AW, 32, address width.
- DW, 32, data width.
- WAIT, 2, memory access cycles; legal range 1..15.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- m0_req  input  1  CPU port access request.
- m0_we  input  1  CPU port write enable.
- m0_adr  input  AW  CPU port address.
- m0_wd  input  DW  CPU port write data.
- m0_rd  output  DW  CPU port read data.
- m0_ack  output  1  CPU port completion pulse.
- m1_req, m1_we, m1_adr, m1_wd, m1_rd, m1_ack: same as the m0_* ports, for the debug/DMA port.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write strobe.
- mem_adr  output  AW  memory address.
- mem_wd  output  DW  memory write data.
- mem_rd  input  DW  memory read data.
- busy  output  1  high whenever the FSM is not in IDLE.
REQ-003 The block SHALL share one single-ported unified memory between the multicycle MIPS core (m0) and a debug/DMA master (m1).

Function
REQ-004 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-005 IDLE with any req high: latch the grantee, its adr, wd and we; load wait counter with WAIT-1; go to ACCESS.
REQ-006 IDLE with no req: remain in IDLE, with all strobes and acks low.
REQ-007 Both req high in IDLE: grant the port not granted most recently (round-robin); after reset, m0 wins first.
REQ-008 ACCESS drives the memory from latched values: mem_en=1, mem_we=latched we, mem_adr/mem_wd = latched values.
REQ-009 In ACCESS the counter SHALL decrement each cycle; counter==0 means the last access cycle; go to DONE.
REQ-010 In the last ACCESS cycle of a read, mem_rd SHALL be registered into the grantee's rd register.
REQ-011 DONE SHALL assert the grantee's ack for exactly one cycle, then return to IDLE.
REQ-012 Latency: req sampled in IDLE at cycle 0 -> mem_en high in cycles 1..WAIT -> ack high in cycle WAIT+1.
REQ-013 Minimum spacing between consecutive grants SHALL be WAIT+2 cycles.
REQ-014 mx_rd SHALL hold its value until that port's next completed read; writes SHALL NOT change mx_rd.
REQ-015 Address, data or we changes after the grant SHALL be ignored for the current access.
REQ-016 A req dropped after the grant SHALL still complete the access and pulse ack.
REQ-017 A req dropped before the grant SHALL cause no access.
REQ-018 A req held high through ack SHALL be treated as a new request at the next IDLE.
REQ-019 The non-granted ack SHALL stay 0, and the two acks SHALL never be high together.
REQ-020 mem_en and mem_we SHALL be 0 outside ACCESS.

Reset
REQ-021 reset low at a clock edge: FSM to IDLE, last-grant to m1, counter 0.
REQ-022 reset low at a clock edge: mem_en, mem_we, m0_ack, m1_ack and busy all 0; m0_rd, m1_rd, mem_adr and mem_wd all 0.
REQ-023 Reset mid-ACCESS or mid-DONE SHALL abort the access with no ack issued; strobes SHALL be low from the next cycle.

Configuration
REQ-024 Macro MEM_ARB_LOCK_EN defined: adds input m0_lock (1 bit).
REQ-025 With MEM_ARB_LOCK_EN: m0_lock high in the DONE cycle of an m0 access, with m0_req high in the following IDLE, SHALL grant m0 regardless of round-robin (atomic read-modify-write).
REQ-026 Without MEM_ARB_LOCK_EN: no m0_lock port, and pure round-robin per REQ-007.

Verification
REQ-027 WAIT=2; m0 read of 0x40 with mem_rd=0xDEADBEEF -> mem_en cycles 1-2, m0_ack cycle 3, m0_rd=0xDEADBEEF.
REQ-028 m0 and m1 req high together, held -> grants m0,m1,m0,m1; acks 4 cycles apart (WAIT=2); never simultaneous.
REQ-029 m1 write adr 0x100, wd 0x12345678 -> mem_we=1, mem_adr=0x100, mem_wd=0x12345678 for exactly WAIT cycles; m1_ack once.
REQ-030 m0_adr changed from 0x40 to 0x80 one cycle after grant -> mem_adr stays 0x40.
REQ-031 reset low during cycle 2 of an ACCESS -> next cycle mem_en=0, busy=0; no ack; next request served by m0 first.
REQ-032 MEM_ARB_LOCK_EN, m0_lock=1, both req high -> two consecutive m0 grants, then m1.
